// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a 2-entry {ins, pc} FIFO into the IF/ID register.
// Optional misaligned-redirect detection is enabled by defining IF_ALIGN_CHECK_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | no request outstanding (FIFO too full to accept another word)
// ST_REQ   | request outstanding at imem_addr, response will be pushed
// ST_DRAIN | request outstanding but stale after a redirect, response dropped
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] ins_out,
   output logic [31:0] pc_out,
   output logic        wr_IF2ID,
   output logic        fetch_misalign
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] ent0_ins_q, ent0_ins_d, ent0_pc_q, ent0_pc_d;
   logic [31:0] ent1_ins_q, ent1_ins_d, ent1_pc_q, ent1_pc_d;

   logic        pop;
   logic        push;
   logic        ack_taken;
   logic        room;
   logic [31:0] redirect_pc_al;

   always_comb begin
      redirect_pc_al = {redirect_pc[31:2], 2'b00};
      ack_taken      = (state_q == ST_REQ) && imem_ack;
      pop            = (cnt_q != 2'd0) && !stall && !redirect_valid;
      push           = ack_taken && !redirect_valid;

      if (redirect_valid)
         cnt_d = 2'd0;
      else
         cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

      if (redirect_valid)
         fetch_pc_d = redirect_pc_al;
      else if (ack_taken)
         fetch_pc_d = fetch_pc_q + 32'd4;
      else
         fetch_pc_d = fetch_pc_q;

      // a new request is only allowed when its response is guaranteed a slot
      room = (cnt_d <= 2'd1);

      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (redirect_valid || room)
               state_d = ST_REQ;
         end
         ST_REQ: begin
            if (redirect_valid && !imem_ack)
               state_d = ST_DRAIN;
            else if (imem_ack)
               state_d = room ? ST_REQ : ST_IDLE;
         end
         ST_DRAIN: begin
            if (imem_ack)
               state_d = ST_REQ;
         end
         default: state_d = ST_IDLE;
      endcase

      addr_d = (state_d == ST_REQ) ? fetch_pc_d : addr_q;
      req_d  = (state_d != ST_IDLE);

      // entry 0 is the head; it keeps its value when the FIFO empties
      ent0_ins_d = ent0_ins_q;
      ent0_pc_d  = ent0_pc_q;
      ent1_ins_d = ent1_ins_q;
      ent1_pc_d  = ent1_pc_q;
      if (!redirect_valid) begin
         if (pop && (cnt_q == 2'd2)) begin
            ent0_ins_d = ent1_ins_q;
            ent0_pc_d  = ent1_pc_q;
         end
         if (push) begin
            if ((cnt_q - {1'b0, pop}) == 2'd0) begin
               ent0_ins_d = imem_rdata;
               ent0_pc_d  = addr_q;
            end else begin
               ent1_ins_d = imem_rdata;
               ent1_pc_d  = addr_q;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         cnt_q      <= 2'd0;
         ent0_ins_q <= 32'h0000_0000;
         ent0_pc_q  <= RESET_PC;
         ent1_ins_q <= 32'h0000_0000;
         ent1_pc_q  <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
         cnt_q      <= cnt_d;
         ent0_ins_q <= ent0_ins_d;
         ent0_pc_q  <= ent0_pc_d;
         ent1_ins_q <= ent1_ins_d;
         ent1_pc_q  <= ent1_pc_d;
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign ins_out   = ent0_ins_q;
   assign pc_out    = ent0_pc_q;
   assign wr_IF2ID  = pop;

`ifdef IF_ALIGN_CHECK_EN
   logic misalign_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         misalign_q <= 1'b0;
      else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
         misalign_q <= 1'b1;
   end

   assign fetch_misalign = misalign_q;
`else
   logic unused_low_bits;

   assign unused_low_bits = ^redirect_pc[1:0];
   assign fetch_misalign  = 1'b0;
`endif

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: the first fetch address after reset SHALL be this value.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory request.
REQ-005 imem_addr  output  32  fetch address; SHALL be word-aligned.
REQ-006 imem_ack  input  1  memory response strobe; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 stall  input  1  decode stall; when high, the IF/ID register SHALL NOT be written.
REQ-009 redirect_valid  input  1  single-cycle PC redirect for a branch, jump or exception.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 ins_out  output  32  instruction presented to the IF/ID register (ins_in).
REQ-012 pc_out  output  32  PC of ins_out, presented to the IF/ID register (pc_in).
REQ-013 wr_IF2ID  output  1  IF/ID register write enable.
REQ-014 fetch_misalign  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-015 Internal state SHALL comprise: fetch PC, a 2-entry FIFO of {instruction, PC}, and an FSM with states IDLE (imem_req=0), REQ (imem_req=1), DRAIN (imem_req=1, response to be discarded).
REQ-016 imem_req and imem_addr SHALL be driven from registers; once imem_req is asserted, both SHALL hold stable until the cycle imem_ack=1.
REQ-017 At most one request SHALL be outstanding.
REQ-018 A request SHALL be issued, or held in REQ after an ack, only when the FIFO count after the current edge is ≤1.
- Otherwise the FSM SHALL go to or stay in IDLE.
- This guarantees room for every response.
REQ-019 On imem_ack in REQ: {imem_rdata, imem_addr} SHALL be pushed to the FIFO, and the fetch PC SHALL advance by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 ins_out and pc_out SHALL equal the FIFO head.
- wr_IF2ID SHALL equal (count≠0) & ~stall.
- When wr_IF2ID=1, the head SHALL pop at that edge.
- A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-021 Latency: an ack at edge N SHALL produce wr_IF2ID=1 in cycle N+1 if stall=0 and the FIFO was empty. With zero-wait memory, sustained throughput SHALL be one instruction per cycle.
REQ-022 When the FIFO is empty, wr_IF2ID SHALL be 0, and ins_out/pc_out SHALL hold their last values.
REQ-023 redirect_valid=1 SHALL take priority over stall and over ack. At that edge:
- the FIFO SHALL be cleared and wr_IF2ID forced 0;
- the fetch PC SHALL be loaded with {redirect_pc[31:2],2'b00}.
REQ-024 If redirect arrives in REQ without ack, the FSM SHALL enter DRAIN and keep the old address. The following ack SHALL be discarded, and the FSM SHALL then go to REQ at the new PC.
REQ-025 If redirect arrives in the same cycle as an ack, that ack's data SHALL be discarded, and the next state SHALL be REQ at the new PC.
REQ-026 A redirect in DRAIN SHALL only update the fetch PC. A redirect in IDLE SHALL go to REQ at the new PC.

Reset
REQ-027 While reset=0, independent of clk:
- imem_req=0, state IDLE;
- imem_addr=fetch PC=RESET_PC;
- FIFO empty, wr_IF2ID=0;
- ins_out=32'h0000_0000, pc_out=RESET_PC;
- fetch_misalign=0.
REQ-028 A reset asserted mid-request SHALL abandon the request immediately. The first rising edge after release SHALL issue a request for RESET_PC.

Configuration
REQ-029 Macro IF_ALIGN_CHECK_EN SHALL control misaligned-redirect detection.
- Defined: fetch_misalign SHALL set at an edge with redirect_valid=1 and redirect_pc[1:0]≠0, and SHALL stay set until reset.
- Undefined: fetch_misalign SHALL be tied 0.
- In both cases, redirect_pc[1:0] SHALL be ignored.

Verification
REQ-030 Zero-wait memory (imem_ack=imem_req), stall=0 after reset: wr_IF2ID=1 every cycle from cycle 2, with pc_out 8000_0000, 8000_0004, 8000_0008, …
REQ-031 stall=1 for 5 cycles with zero-wait memory: the FIFO fills to 2 and imem_req drops. On release, 8000_0008 and 8000_000C are written in order with no loss or duplicate.
REQ-032 3-cycle ack latency, redirect_pc=0000_1000 in the second wait cycle: the pending 8000_0004 response is discarded. The next imem_addr is 0000_1000, and the next pc_out written is 0000_1000.
REQ-033 redirect coincident with ack: the acked word is never presented, and the FIFO is empty next cycle.
REQ-034 RESET_PC=32'hFFFF_FFFC: the second fetch address is 0000_0000.
REQ-035 With IF_ALIGN_CHECK_EN defined, redirect_pc=0000_2002: fetch_misalign=1 until reset, and imem_addr=0000_2000. With the macro undefined, fetch_misalign stays 0.
